data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Memory-side responder of the CPU data-memory READ/WRITE/BUSYWAIT handshake, used by lw/sw style instructions.
//   Holds a DEPTH x DATA_WIDTH storage array and models a fixed multi-cycle access latency.
//   While an access is in progress it asserts BUSYWAIT, which stalls the PC and register write-back.
// PARAMETERS
//   DATA_WIDTH      8    width of one memory word / CPU data bus
//   ADDR_WIDTH      8    address width; DEPTH = 2**ADDR_WIDTH
//   ACCESS_LATENCY  5    cycles BUSYWAIT stays high after acceptance (>=1)
// PORTS
//   CLK        in   1           single clock; all state updates on posedge
//   RESET      in   1           synchronous, active-low reset (sampled on posedge CLK)
//   READ       in   1           CPU read request, level, held until BUSYWAIT falls
//   WRITE      in   1           CPU write request, level, held until BUSYWAIT falls
//   ADDRESS    in   ADDR_WIDTH  word address
//   WRITEDATA  in   DATA_WIDTH  store data
//   READDATA   out  DATA_WIDTH  load data, registered
//   BUSYWAIT   out  1           stall request to CPU
// BEHAVIOUR
//   Reset (RESET==0 at posedge): state=IDLE, count=0, READDATA=0, all array words=0.
//   Reset mid-access aborts the access. A pending write is NOT committed.
//   FSM states: IDLE, BUSY, DONE.
//   BUSYWAIT is combinational and has no delay:
//     BUSYWAIT = (IDLE & (READ|WRITE)) | BUSY.
//     This raises the stall in the same cycle as the request.
//   IDLE, posedge with READ|WRITE:
//     latch op, ADDRESS and WRITEDATA.
//     count <= ACCESS_LATENCY-1.
//     go to BUSY.
//   BUSY, posedge with count!=0: count <= count-1. Input changes are ignored because operands are latched.
//   BUSY, posedge with count==0:
//     perform the access using the latched values.
//     Read: READDATA <= mem[addr]. Write: mem[addr] <= data.
//     go to DONE.
//   Resulting timing:
//     BUSYWAIT is high for exactly ACCESS_LATENCY+1 cycles, counting the request cycle.
//     READDATA is valid from the cycle BUSYWAIT falls.
//   DONE: BUSYWAIT=0 and all requests are ignored for one cycle.
//     This absorbs the PC-update edge where the old READ/WRITE is still asserted.
//     Next posedge always returns to IDLE.
//   Simultaneous READ & WRITE: the read is performed and the write is suppressed.
//   READDATA holds the last read value across writes and idle cycles. Writes never change READDATA.
//   No address wrap: ADDRESS spans the full array, so no out-of-range case exists.
//   Back-to-back accesses: minimum spacing is one idle-capable cycle (DONE) between accesses.
// STRUCTURE
//   Shared package mem_pkg:
//     state encoding localparams MEM_IDLE=2'd0, MEM_BUSY=2'd1, MEM_DONE=2'd2.
//     default latency constant MEM_LATENCY=5.
//     op encoding OP_RD=1'b0, OP_WR=1'b1.
//   One sub-module mem_latency_counter(CLK, RESET, LOAD, LOAD_VAL, ZERO):
//     down-counter, width $clog2(ACCESS_LATENCY)+1, sync active-low reset.
//   FSM, operand latches and storage array live in the top module.
// TESTING
//   1. Reset: hold RESET=0 for 2 cycles, then release.
//      -> BUSYWAIT=0, READDATA=8'h00; a read of any address returns 8'h00.
//   2. Write then read: WRITE, ADDRESS=8'h10, WRITEDATA=8'hA5; then READ at 8'h10.
//      -> BUSYWAIT high 6 cycles for each access; READDATA=8'hA5 when BUSYWAIT falls.
//   3. Operand latch: change ADDRESS 8'h10->8'h20 during BUSY of a write of 8'h3C.
//      -> mem[8'h10]=8'h3C and mem[8'h20] is unchanged.
//   4. DONE absorption: keep READ high one extra cycle after BUSYWAIT falls.
//      -> no new access starts in DONE; a request still high in IDLE starts a new access.
//   5. Reset mid-write: assert RESET=0 during the 3rd BUSY cycle of a write of 8'hFF to 8'h05.
//      -> BUSYWAIT=0 next cycle; mem[8'h05] reads 8'h00.
//   6. Conflict: READ=WRITE=1 at 8'h07 with WRITEDATA=8'h99, where mem[8'h07]=8'h11.
//      -> READDATA=8'h11 and mem[8'h07] remains 8'h11.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state, latency and op encodings for the data-memory responder
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_t;

    localparam int MEM_LATENCY = 5;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/mem_latency_counter.sv
// rtl/mem_latency_counter.sv - loadable down-counter that parks at zero
module mem_latency_counter
    import mem_pkg::*;
#(
    parameter int  ACCESS_LATENCY = MEM_LATENCY,
    localparam int CW             = $clog2(ACCESS_LATENCY) + 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          LOAD,
    input  logic [CW-1:0] LOAD_VAL,
    output logic          ZERO
);

    logic [CW-1:0] count;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            count <= '0;
        end else if (LOAD) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign ZERO = (count == '0);

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency data memory answering the CPU READ/WRITE/BUSYWAIT handshake
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int ACCESS_LATENCY = MEM_LATENCY
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [DATA_WIDTH-1:0] WRITEDATA,
    output logic [DATA_WIDTH-1:0] READDATA,
    output logic                  BUSYWAIT
);

    localparam int            DEPTH    = 2 ** ADDR_WIDTH;
    localparam int            CW       = $clog2(ACCESS_LATENCY) + 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(ACCESS_LATENCY - 1);

    mem_state_t state, state_next;

    logic                  op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic capture;
    logic do_access;
    logic cnt_load;
    logic cnt_zero;

    mem_latency_counter #(
        .ACCESS_LATENCY(ACCESS_LATENCY)
    ) u_latency (
        .CLK     (CLK),
        .RESET   (RESET),
        .LOAD    (cnt_load),
        .LOAD_VAL(LOAD_VAL),
        .ZERO    (cnt_zero)
    );

    always_comb begin
        state_next = state;
        BUSYWAIT   = 1'b0;
        capture    = 1'b0;
        do_access  = 1'b0;
        cnt_load   = 1'b0;
        unique case (state)
            MEM_IDLE: begin
                if (READ || WRITE) begin
                    BUSYWAIT   = 1'b1;
                    capture    = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = MEM_BUSY;
                end
            end
            MEM_BUSY: begin
                BUSYWAIT = 1'b1;
                if (cnt_zero) begin
                    do_access  = 1'b1;
                    state_next = MEM_DONE;
                end
            end
            // DONE swallows the request still held during the CPU's PC-update edge
            MEM_DONE: state_next = MEM_IDLE;
            default:  state_next = MEM_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= MEM_IDLE;
            op_q     <= OP_RD;
            addr_q   <= '0;
            wdata_q  <= '0;
            READDATA <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (capture) begin
                // a read wins when both requests are raised together
                op_q    <= READ ? OP_RD : OP_WR;
                addr_q  <= ADDRESS;
                wdata_q <= WRITEDATA;
            end
            if (do_access) begin
                if (op_q == OP_RD) begin
                    READDATA <= mem[addr_q];
                end else begin
                    mem[addr_q] <= wdata_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

    logic       clk;
    logic       resetn;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;

    int n_cmp;
    int n_fail;

    data_mem_responder #(
        .DATA_WIDTH    (8),
        .ADDR_WIDTH    (8),
        .ACCESS_LATENCY(5)
    ) dut (
        .CLK      (clk),
        .RESET    (resetn),
        .READ     (rd),
        .WRITE    (wr),
        .ADDRESS  (addr),
        .WRITEDATA(wdata),
        .READDATA (rdata),
        .BUSYWAIT (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Raises the request at a negedge, counts cycles with BUSYWAIT high, returns READDATA
    // in the cycle BUSYWAIT falls and drops the request there. Optionally retargets the
    // address/data inputs once chg_cycle high cycles have been seen.
    task automatic access(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                          input int chg_cycle, input logic [7:0] chg_a, input logic [7:0] chg_d,
                          output int hi, output logic [7:0] q);
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d;
        hi = 0;
        #1;
        while (busy === 1'b1 && hi < 50) begin
            hi++;
            if (hi == chg_cycle) begin
                addr = chg_a; wdata = chg_d;
            end
            @(negedge clk);
            #1;
        end
        q = rdata;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic test_reset();
        int hi;
        logic [7:0] q;
        resetn = 1'b0; rd = 1'b0; wr = 1'b0; addr = 8'h00; wdata = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busywait: got %b want 0", busy);
        end
        n_cmp++;
        if (rdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_readdata: got %h want 00", rdata);
        end
        access(1'b1, 1'b0, 8'h33, 8'h00, -1, 8'h00, 8'h00, hi, q);
        n_cmp++;
        if (q !== 8'h00) begin
            n_fail++; $display("FAIL reset_read_33: got %h want 00", q);
        end
    endtask

    task automatic test_write_read();
        int hi;
        logic [7:0] q;
        access(1'b0, 1'b1, 8'h10, 8'hA5, -1, 8'h00, 8'h00, hi, q);
        n_cmp++;
        if (hi !== 6) begin
            n_fail++; $display("FAIL wr_busy_cycles: got %0d want 6", hi);
        end
        n_cmp++;
        if (q !== 8'h00) begin
            n_fail++; $display("FAIL wr_keeps_readdata: got %h want 00", q);
        end
        access(1'b1, 1'b0, 8'h10, 8'h00, -1, 8'h00, 8'h00, hi, q);
        n_cmp++;
        if (hi !== 6) begin
            n_fail++; $display("FAIL rd_busy_cycles: got %0d want 6", hi);
        end
        n_cmp++;
        if (q !== 8'hA5) begin
            n_fail++; $display("FAIL rd_10: got %h want a5", q);
        end
    endtask

    task automatic test_operand_latch();
        int hi;
        logic [7:0] q;
        access(1'b0, 1'b1, 8'h20, 8'h5A, -1, 8'h00, 8'h00, hi, q);
        access(1'b0, 1'b1, 8'h10, 8'h3C, 2, 8'h20, 8'h77, hi, q);
        n_cmp++;
        if (hi !== 6) begin
            n_fail++; $display("FAIL latch_busy_cycles: got %0d want 6", hi);
        end
        n_cmp++;
        if (q !== 8'hA5) begin
            n_fail++; $display("FAIL latch_keeps_readdata: got %h want a5", q);
        end
        access(1'b1, 1'b0, 8'h10, 8'h00, -1, 8'h00, 8'h00, hi, q);
        n_cmp++;
        if (q !== 8'h3C) begin
            n_fail++; $display("FAIL latch_rd_10: got %h want 3c", q);
        end
        access(1'b1, 1'b0, 8'h20, 8'h00, -1, 8'h00, 8'h00, hi, q);
        n_cmp++;
        if (q !== 8'h5A) begin
            n_fail++; $display("FAIL latch_rd_20: got %h want 5a", q);
        end
    endtask

    task automatic test_done_absorb();
        int hi;
        logic [7:0] q;
        access(1'b1, 1'b0, 8'h20, 8'h00, -1, 8'h00, 8'h00, hi, q);
        // re-raise READ in the DONE cycle, now pointing at 8'h10
        rd = 1'b1; addr = 8'h10;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL done_busywait: got %b want 0", busy);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL idle_restart_busywait: got %b want 1", busy);
        end
        hi = 0;
        while (busy === 1'b1 && hi < 50) begin
            hi++;
            @(negedge clk);
            #1;
        end
        rd = 1'b0;
        n_cmp++;
        if (hi !== 6) begin
            n_fail++; $display("FAIL restart_busy_cycles: got %0d want 6", hi);
        end
        n_cmp++;
        if (rdata !== 8'h3C) begin
            n_fail++; $display("FAIL restart_rd_10: got %h want 3c", rdata);
        end
    endtask

    task automatic test_reset_mid_write();
        int hi;
        logic [7:0] q;
        @(negedge clk);
        wr = 1'b1; addr = 8'h05; wdata = 8'hFF;
        repeat (3) @(negedge clk);
        resetn = 1'b0; wr = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_busywait: got %b want 0", busy);
        end
        n_cmp++;
        if (rdata !== 8'h00) begin
            n_fail++; $display("FAIL midrst_readdata: got %h want 00", rdata);
        end
        resetn = 1'b1;
        access(1'b1, 1'b0, 8'h05, 8'h00, -1, 8'h00, 8'h00, hi, q);
        n_cmp++;
        if (q !== 8'h00) begin
            n_fail++; $display("FAIL midrst_rd_05: got %h want 00", q);
        end
        access(1'b1, 1'b0, 8'h10, 8'h00, -1, 8'h00, 8'h00, hi, q);
        n_cmp++;
        if (q !== 8'h00) begin
            n_fail++; $display("FAIL midrst_rd_10_cleared: got %h want 00", q);
        end
    endtask

    task automatic test_conflict();
        int hi;
        logic [7:0] q;
        access(1'b0, 1'b1, 8'h07, 8'h11, -1, 8'h00, 8'h00, hi, q);
        access(1'b1, 1'b1, 8'h07, 8'h99, -1, 8'h00, 8'h00, hi, q);
        n_cmp++;
        if (hi !== 6) begin
            n_fail++; $display("FAIL conflict_busy_cycles: got %0d want 6", hi);
        end
        n_cmp++;
        if (q !== 8'h11) begin
            n_fail++; $display("FAIL conflict_readdata: got %h want 11", q);
        end
        access(1'b1, 1'b0, 8'h07, 8'h00, -1, 8'h00, 8'h00, hi, q);
        n_cmp++;
        if (q !== 8'h11) begin
            n_fail++; $display("FAIL conflict_mem_07: got %h want 11", q);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_write_read();
        test_operand_latch();
        test_done_absorb();
        test_reset_mid_write();
        test_conflict();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
